// File: rtl/adc_cap_pkg.sv
// rtl/adc_cap_pkg.sv - shared widths, FSM state type and ramp helper for adc_frame_capture
package adc_cap_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 16;
  localparam int WORD_W = NUM_CH * CH_W;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SKIP,
    ST_CAPTURE
  } cap_state_t;

  // Test-pattern word: channel n carries base + n, channel 0 in the low lane.
  function automatic logic [WORD_W-1:0] ramp_word(input logic [CH_W-1:0] base);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      w[n*CH_W +: CH_W] = base + CH_W'(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/adc_cap_fifo.sv
// rtl/adc_cap_fifo.sv - first-word-fall-through FIFO; accepts a push into a full FIFO when the same edge pops
module adc_cap_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 65
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_pop;
  logic              do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is gated so the output reads zero whenever nothing is held.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/adc_frame_capture.sv
// rtl/adc_frame_capture.sv - trigger-synchronised ADC frame capture into a FWFT stream FIFO
// Define ADC_CAP_TEST_PATTERN_EN to replace the channel inputs with an internal ramp.
module adc_frame_capture
  import adc_cap_pkg::*;
#(
  parameter int FRAME_LEN  = 1024,
  parameter int SKIP_LEN   = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              CLK_DIV_IN,
  input  logic              IO_RESET,
  input  logic              arm,
  input  logic              cont,
  input  logic              trig,
  input  logic [CH_W-1:0]   CH1_DATA,
  input  logic [CH_W-1:0]   CH2_DATA,
  input  logic [CH_W-1:0]   CH3_DATA,
  input  logic [CH_W-1:0]   CH4_DATA,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [CNT_W-1:0] SKIP_LAST  = CNT_W'((SKIP_LEN == 0) ? 0 : SKIP_LEN - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

  cap_state_t        state;
  cap_state_t        next_state;
  logic [CNT_W-1:0]  cnt;
  logic              trig_q;
  logic              trig_rise;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              wr_en;
  logic              wr_last;
  logic              frame_done;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W:0]   fifo_out;
  logic [WORD_W-1:0] cap_word;

  assign trig_rise = trig & ~trig_q;
  assign pop       = m_valid & m_ready;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    wr_en      = 1'b0;
    wr_last    = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm) next_state = ST_ARMED;
      end
      ST_ARMED: begin
        if (trig_rise) begin
          next_state = (SKIP_LEN == 0) ? ST_CAPTURE : ST_SKIP;
          cnt_clr    = 1'b1;
        end
      end
      ST_SKIP: begin
        if (cnt == SKIP_LAST) begin
          next_state = ST_CAPTURE;
          cnt_clr    = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_CAPTURE: begin
        wr_en = 1'b1;
        if (cnt == FRAME_LAST) begin
          wr_last    = 1'b1;
          frame_done = 1'b1;
          cnt_clr    = 1'b1;
          next_state = cont ? ST_ARMED : ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_DIV_IN or posedge IO_RESET) begin
    if (IO_RESET) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      trig_q    <= 1'b0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      state  <= next_state;
      trig_q <= trig;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (frame_done)   frame_cnt <= frame_cnt + CNT_W'(1);
      // A dropped word only happens in CAPTURE, so the IDLE clear never races it.
      if (state == ST_IDLE && arm)             overflow <= 1'b0;
      else if (wr_en && fifo_full && !pop)     overflow <= 1'b1;
    end
  end

`ifdef ADC_CAP_TEST_PATTERN_EN
  logic [CH_W-1:0] ramp;
  logic            unused_ch;

  assign unused_ch = ^{CH1_DATA, CH2_DATA, CH3_DATA, CH4_DATA};
  assign cap_word  = ramp_word(ramp);

  always_ff @(posedge CLK_DIV_IN or posedge IO_RESET) begin
    if (IO_RESET)                ramp <= '0;
    else if (state != ST_CAPTURE) ramp <= '0;
    else                          ramp <= ramp + CH_W'(1);
  end
`else
  assign cap_word = {CH4_DATA, CH3_DATA, CH2_DATA, CH1_DATA};
`endif

  adc_cap_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (WORD_W + 1)
  ) u_fifo (
    .clk       (CLK_DIV_IN),
    .rst       (IO_RESET),
    .push      (wr_en),
    .push_data ({wr_last, cap_word}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_valid = ~fifo_empty;
  assign m_data  = fifo_out[WORD_W-1:0];
  assign m_last  = fifo_out[WORD_W];

endmodule

// File: tb/tb_adc_frame_capture.sv
// tb/tb_adc_frame_capture.sv - randomized bench for adc_frame_capture against a queue-based frame model
module tb_adc_frame_capture;

  localparam int FRAME_LEN  = 8;
  localparam int SKIP_LEN   = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm, cont, trig, m_ready;
  logic [15:0] ch1, ch2, ch3, ch4;
  logic [63:0] m_data;
  logic        m_valid, m_last, busy, overflow;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  adc_frame_capture #(
    .FRAME_LEN  (FRAME_LEN),
    .SKIP_LEN   (SKIP_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK_DIV_IN (clk),
    .IO_RESET   (rst),
    .arm        (arm),
    .cont       (cont),
    .trig       (trig),
    .CH1_DATA   (ch1),
    .CH2_DATA   (ch2),
    .CH3_DATA   (ch3),
    .CH4_DATA   (ch4),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .overflow   (overflow),
    .frame_cnt  (frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: a frame is "edges since the trigger edge"; edges SKIP+1..SKIP+FRAME carry words.
  bit          md_armed, md_frame, md_trig_prev, md_ovf;
  int          md_since, md_fcnt;
  logic [64:0] md_q[$];

  task automatic model_reset();
    md_armed = 0; md_frame = 0; md_trig_prev = 0; md_ovf = 0;
    md_since = 0; md_fcnt = 0;
    md_q.delete();
  endtask

  task automatic model_edge();
    int          occ;
    bit          pop, push, lst;
    logic [63:0] w;
    int          k;
    occ  = md_q.size();
    pop  = (occ > 0) && m_ready;
    push = 0; lst = 0; w = '0;
    if (md_frame) begin
      md_since++;
      if (md_since > SKIP_LEN) begin
        push = 1;
        lst  = (md_since == SKIP_LEN + FRAME_LEN);
        k    = md_since - SKIP_LEN - 1;
`ifdef ADC_CAP_TEST_PATTERN_EN
        w = {16'(k + 3), 16'(k + 2), 16'(k + 1), 16'(k)};
`else
        w = {ch4, ch3, ch2, ch1};
`endif
      end
      if (md_since == SKIP_LEN + FRAME_LEN) begin
        md_frame = 0;
        md_fcnt++;
        md_armed = cont;
      end
    end else if (md_armed) begin
      if (trig && !md_trig_prev) begin
        md_armed = 0;
        md_frame = 1;
        md_since = 0;
      end
    end else if (arm) begin
      md_armed = 1;
      md_ovf   = 0;
    end
    if (pop) md_q.delete(0);
    if (push) begin
      if (occ < FIFO_DEPTH || pop) md_q.push_back({lst, w});
      else                         md_ovf = 1;
    end
    md_trig_prev = trig;
  endtask

  task automatic check_outputs();
    check_eq("m_valid", m_valid, 64'(md_q.size() != 0));
    if (md_q.size() != 0) begin
      check_eq("m_data", m_data, md_q[0][63:0]);
      check_eq("m_last", m_last, 64'(md_q[0][64]));
    end
    check_eq("busy", busy, 64'(md_armed || md_frame));
    check_eq("overflow", overflow, 64'(md_ovf));
    check_eq("frame_cnt", frame_cnt, 64'(16'(md_fcnt)));
  endtask

  task automatic step(input bit a, input bit c, input bit t, input bit r);
    @(negedge clk);
    check_outputs();
    arm = a; cont = c; trig = t; m_ready = r;
    ch1 = 16'($urandom); ch2 = 16'($urandom); ch3 = 16'($urandom); ch4 = 16'($urandom);
    model_edge();
  endtask

  // ready_mode: 0 = stalled, 1 = always ready, 2 = random
  task automatic random_phase(input int ncyc, input int ready_mode, input bit c);
    bit r;
    for (int i = 0; i < ncyc; i++) begin
      r = (ready_mode == 1) ? 1'b1 : (ready_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      step($urandom_range(0, 7) == 0, c, ($urandom_range(0, 3) == 0) ? ~trig : trig, r);
    end
  endtask

  initial begin
    bit idle_seen;
    rst = 1'b1; arm = 0; cont = 0; trig = 0; m_ready = 0;
    ch1 = 0; ch2 = 0; ch3 = 0; ch4 = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_m_data", m_data, 64'd0);
    check_eq("rst_m_last", m_last, 64'd0);
    check_outputs();
    rst = 1'b0;
    model_edge();

    random_phase(300, 2, 1'b0);
    random_phase(300, 1, 1'b1);
    random_phase(200, 0, 1'b0);
    random_phase(100, 1, 1'b0);
    random_phase(300, 2, 1'b1);

    idle_seen = 0;
    for (int i = 0; i < 200 && !idle_seen; i++) begin
      step(0, 0, (md_armed || md_frame) ? ~trig : 1'b0, 1);
      idle_seen = !(md_armed || md_frame);
    end
    check_eq("drain_to_idle", 64'(idle_seen), 64'd1);

    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    repeat (SKIP_LEN + 4) step(0, 0, 1, 1);
    check_eq("pre_reset_valid", m_valid, 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_valid", m_valid, 64'd0);
    check_eq("async_rst_busy", busy, 64'd0);
    check_eq("async_rst_last", m_last, 64'd0);
    check_eq("async_rst_frame_cnt", frame_cnt, 64'd0);
    check_eq("async_rst_overflow", overflow, 64'd0);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst = 1'b0; arm = 0; trig = 0;
    model_edge();

    random_phase(300, 2, 1'b1);
    random_phase(100, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
